// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe_if
//  Brief    : Operand/result handshake bundle for alu_pipe. The sat_mode
//             signal is present only when ALU_SAT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================

interface alu_pipe_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   opcode;
`ifdef ALU_SAT_EN
    logic             sat_mode;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   res;
    logic             zf;
    logic             cf;
    logic             vf;
    logic             nf;

`ifdef ALU_SAT_EN
    modport master (
        output in_valid, a, b, opcode, sat_mode, out_ready,
        input  in_ready, out_valid, res, zf, cf, vf, nf
    );
    modport slave (
        input  in_valid, a, b, opcode, sat_mode, out_ready,
        output in_ready, out_valid, res, zf, cf, vf, nf
    );
`else
    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, res, zf, cf, vf, nf
    );
    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, res, zf, cf, vf, nf
    );
`endif
endinterface

`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Brief    : Two-stage valid/ready pipelined ALU (ADD SUB INC DEC AND OR NOT
//             XOR) with registered Z/C/V/N flags. Define ALU_SAT_EN to add
//             unsigned saturation selected by sat_mode.
//  Revision : 1.0  initial release
// ============================================================================

module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic enable,
    alu_pipe_if.slave bus
);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_INC = OPW'(2);
    localparam logic [OPW-1:0] OP_DEC = OPW'(3);
    localparam logic [OPW-1:0] OP_AND = OPW'(4);
    localparam logic [OPW-1:0] OP_OR  = OPW'(5);
    localparam logic [OPW-1:0] OP_NOT = OPW'(6);
    localparam logic [OPW-1:0] OP_XOR = OPW'(7);

    generate
        if (OPW != 3) begin : g_bad_opw
            $error("alu_pipe: OPW is reserved and must stay at 3");
        end
        if (WIDTH < 2) begin : g_bad_width
            $error("alu_pipe: WIDTH must be at least 2");
        end
    endgenerate

    // ---------------- state ----------------
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
`ifdef ALU_SAT_EN
    logic             sat_q, sat_d;
`endif
    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   res_q, res_d;
    logic             zf_q, zf_d;
    logic             cf_q, cf_d;
    logic             vf_q, vf_d;
    logic             nf_q, nf_d;

    // ---------------- handshake ----------------
    logic s2_ready;
    logic in_ready;
    logic capture;
    logic advance;
    logic drain;

    assign s2_ready = !out_valid_q || bus.out_ready;
    assign in_ready = enable && (!s1_valid_q || s2_ready);
    assign capture  = bus.in_valid && in_ready;
    assign advance  = enable && s1_valid_q && s2_ready;
    // A consumer may finish taking the current result even while stalled.
    assign drain    = out_valid_q && bus.out_ready;

    // ---------------- stage 2 datapath ----------------
    logic [WIDTH-1:0] opb;
    logic             is_arith;
    logic             is_sub;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH:0]   calc_res;
    logic             calc_cf;
    logic             calc_vf;

    always_comb begin
        opb       = b_q;
        is_arith  = 1'b0;
        is_sub    = 1'b0;
        logic_res = '0;
        case (op_q)
            OP_ADD: is_arith = 1'b1;
            OP_SUB: begin
                is_arith = 1'b1;
                is_sub   = 1'b1;
            end
            OP_INC: begin
                is_arith = 1'b1;
                opb      = WIDTH'(1);
            end
            OP_DEC: begin
                is_arith = 1'b1;
                is_sub   = 1'b1;
                opb      = WIDTH'(1);
            end
            OP_AND:  logic_res = a_q & b_q;
            OP_OR:   logic_res = a_q | b_q;
            OP_NOT:  logic_res = ~a_q;
            OP_XOR:  logic_res = a_q ^ b_q;
            default: logic_res = '0;
        endcase
    end

    // Top bit of the WIDTH+1 result is carry for add, borrow for subtract.
    assign sum = is_sub ? ({1'b0, a_q} - {1'b0, opb})
                        : ({1'b0, a_q} + {1'b0, opb});

    assign ovf = is_sub
        ? ((a_q[WIDTH-1] != opb[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]))
        : ((a_q[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]));

    always_comb begin
        if (is_arith) begin
            calc_res = sum;
            calc_cf  = sum[WIDTH];
            calc_vf  = ovf;
`ifdef ALU_SAT_EN
            // Clamp on carry/borrow; cf and vf still describe the raw result.
            if (sat_q && sum[WIDTH]) begin
                calc_res = {1'b0, (is_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}})};
            end
`endif
        end else begin
            calc_res = {1'b0, logic_res};
            calc_cf  = 1'b0;
            calc_vf  = 1'b0;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
`ifdef ALU_SAT_EN
        sat_d      = sat_q;
`endif
        if (advance) begin
            s1_valid_d = 1'b0;
        end
        if (capture) begin
            s1_valid_d = 1'b1;
            a_d        = bus.a;
            b_d        = bus.b;
            op_d       = bus.opcode;
`ifdef ALU_SAT_EN
            sat_d      = bus.sat_mode;
`endif
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        res_d       = res_q;
        zf_d        = zf_q;
        cf_d        = cf_q;
        vf_d        = vf_q;
        nf_d        = nf_q;
        if (advance) begin
            out_valid_d = 1'b1;
            res_d       = calc_res;
            zf_d        = (calc_res[WIDTH-1:0] == '0);
            cf_d        = calc_cf;
            vf_d        = calc_vf;
            nf_d        = calc_res[WIDTH-1];
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
`ifdef ALU_SAT_EN
            sat_q       <= 1'b0;
`endif
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zf_q        <= 1'b0;
            cf_q        <= 1'b0;
            vf_q        <= 1'b0;
            nf_q        <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
`ifdef ALU_SAT_EN
            sat_q       <= sat_d;
`endif
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            zf_q        <= zf_d;
            cf_q        <= cf_d;
            vf_q        <= vf_d;
            nf_q        <= nf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign bus.zf        = zf_q;
    assign bus.cf        = cf_q;
    assign bus.vf        = vf_q;
    assign bus.nf        = nf_q;

endmodule

`default_nettype wire
